// File: rtl/switch_reg_bank_ctrl.sv
// switch_reg_bank_ctrl: configuration register bank for a switch router.
// Holds per-outport dateline flags, a write-lock bit and a small route LUT.
// Config accesses use a single-outstanding request/response handshake.
// Lookups are serviced every cycle with one cycle of latency.
// Optional feature macro: SWITCH_REG_BANK_READBACK_EN enables register reads.
// Without the macro, every read returns an error.
module switch_reg_bank_ctrl #(
  parameter int NUM_OUTPORTS = 5,
  parameter int TABLE_SIZE   = 8,
  parameter int NODE_ID_W    = 5,
  localparam int PORT_W      = $clog2(NUM_OUTPORTS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_write,
  input  logic [7:0]              cfg_addr,
  input  logic [31:0]             cfg_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_err,
  output logic [31:0]             rsp_rdata,
  input  logic                    lkp_valid,
  input  logic [NODE_ID_W-1:0]    lkp_dest,
  output logic                    lkp_hit,
  output logic [PORT_W-1:0]       lkp_port,
  output logic                    lkp_done,
  output logic [NUM_OUTPORTS-1:0] dateline
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic                 lock;
  logic                 lut_valid [TABLE_SIZE];
  logic [PORT_W-1:0]    lut_port  [TABLE_SIZE];
  logic [NODE_ID_W-1:0] lut_dest  [TABLE_SIZE];

  logic              accept;
  logic [4:0]        idx;
  logic              is_dl, is_lock, is_lut, mapped, port_bad;
  logic              err_c;
  logic [31:0]       rdata_c;
  logic              hit_c;
  logic [PORT_W-1:0] port_c;
  logic              unused_wdata;

  // Upper write-data bits are deliberately dropped by every field.
  assign unused_wdata = ^cfg_wdata;

  assign accept   = cfg_valid && cfg_ready;
  assign idx      = cfg_addr[4:0];
  assign is_dl    = (cfg_addr == 8'h00);
  assign is_lock  = (cfg_addr == 8'h01);
  assign is_lut   = (cfg_addr[7:5] == 3'b001) && (32'(idx) < TABLE_SIZE);
  assign mapped   = is_dl || is_lock || is_lut;
  assign port_bad = (32'(cfg_wdata[16 +: PORT_W]) >= NUM_OUTPORTS);

  // Handshake state register; reset abandons any pending response.
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; ready is held low while in reset.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = nRST;
        if (cfg_valid && nRST) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SWITCH_REG_BANK_READBACK_EN
  logic [31:0] rd_val;

  // Read mux assembling the register image for the addressed location.
  always_comb begin
    rd_val = '0;
    if (is_dl) begin
      rd_val = 32'(dateline);
    end else if (is_lock) begin
      rd_val = {31'b0, lock};
    end else if (is_lut) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        if (idx == i[4:0]) begin
          rd_val[31]              = lut_valid[i];
          rd_val[16 +: PORT_W]    = lut_port[i];
          rd_val[NODE_ID_W-1:0]   = lut_dest[i];
        end
      end
    end
  end
`endif

  // Error classification and response data for the request being accepted.
  always_comb begin
    err_c   = 1'b0;
    rdata_c = '0;
    if (cfg_write) begin
      err_c = !mapped || (lock && !is_lock) || (is_lut && port_bad);
    end else begin
`ifdef SWITCH_REG_BANK_READBACK_EN
      err_c   = !mapped;
      rdata_c = mapped ? rd_val : 32'h0;
`else
      err_c   = 1'b1;
`endif
    end
  end

  // Register file update: a write commits on the accepting edge when legal.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dateline <= '0;
      lock     <= 1'b0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
        lut_valid[i] <= 1'b0;
        lut_port[i]  <= '0;
        lut_dest[i]  <= '0;
      end
    end else if (accept && cfg_write && !err_c) begin
      if (is_dl)   dateline <= cfg_wdata[NUM_OUTPORTS-1:0];
      if (is_lock) lock     <= cfg_wdata[0];
      if (is_lut) begin
        for (int i = 0; i < TABLE_SIZE; i++) begin
          if (idx == i[4:0]) begin
            lut_valid[i] <= cfg_wdata[31];
            lut_port[i]  <= cfg_wdata[16 +: PORT_W];
            lut_dest[i]  <= cfg_wdata[NODE_ID_W-1:0];
          end
        end
      end
    end
  end

  // Response capture at acceptance; held stable throughout RESP.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_err   <= err_c;
      rsp_rdata <= rdata_c;
    end
  end

  // Priority match: the descending scan leaves the lowest matching index.
  always_comb begin
    hit_c  = 1'b0;
    port_c = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (lut_valid[i] && (lut_dest[i] == lkp_dest)) begin
        hit_c  = 1'b1;
        port_c = lut_port[i];
      end
    end
  end

  // Registered lookup result; the table seen is the pre-write contents.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      lkp_done <= 1'b0;
      lkp_hit  <= 1'b0;
      lkp_port <= '0;
    end else begin
      lkp_done <= lkp_valid;
      if (lkp_valid) begin
        lkp_hit  <= hit_c;
        lkp_port <= port_c;
      end
    end
  end

endmodule
